// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter. One shared ALU feeds a single result register
// with a valid/ready handshake; grants are round-robin or fixed priority.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    // Result register occupancy.
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]  r_state;
    logic        r_prio;
    logic [31:0] r_rsp_data;
    logic        r_rsp_id;
    logic        r_rsp_err;

    logic        w_can_accept;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [3:0]  w_op;
    logic [3:0]  w_sh;
    logic [31:0] w_result;
    logic        w_err;

    // Handshake: a requester's ready depends only on the other's valid.
    always_comb begin
        w_can_accept = (r_state == S_EMPTY) || rsp_ready;
        req0_ready   = w_can_accept && (!req1_valid || (r_prio == 1'b0));
        req1_ready   = w_can_accept && (!req0_valid || (r_prio == 1'b1));
        w_grant0     = req0_valid && req0_ready;
        w_grant1     = req1_valid && req1_ready;
        w_accept     = w_grant0 || w_grant1;
    end

    // Operand mux: the two grants are mutually exclusive by construction.
    always_comb begin
        w_a  = w_grant1 ? req1_a  : req0_a;
        w_b  = w_grant1 ? req1_b  : req0_b;
        w_op = w_grant1 ? req1_op : req0_op;
        w_sh = w_a[3:0];
    end

    // Shared ALU; unused opcodes yield zero and flag an error.
    always_comb begin
        w_result = 32'd0;
        w_err    = 1'b0;
        case (w_op)
            OP_ADD:  w_result = w_a + w_b;
            OP_SUB:  w_result = w_a - w_b;
            OP_SLL:  w_result = w_b << w_sh;
            OP_SRL:  w_result = w_b >> w_sh;
            OP_SLT:  w_result = {31'd0, ($signed(w_a) < $signed(w_b))};
            OP_AND:  w_result = w_a & w_b;
            OP_OR:   w_result = w_a | w_b;
            OP_XOR:  w_result = w_a ^ w_b;
            OP_SLTU: w_result = {31'd0, (w_a < w_b)};
            OP_SRA:  w_result = $signed(w_b) >>> w_sh;
            default: begin
                w_result = 32'd0;
                w_err    = 1'b1;
            end
        endcase
    end

    // Occupancy FSM: fill on accept, drain on consume without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) r_state <= S_FULL;
                S_FULL:  if (rsp_ready && !w_accept) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Result payload is captured only at the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= 32'd0;
            r_rsp_id   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_data <= w_result;
            r_rsp_id   <= w_grant1;
            r_rsp_err  <= w_err;
        end
    end

    // Priority pointer: flips to the loser after each grant in round-robin
    // mode, stays at requester 0 in fixed-priority mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (RR_EN && w_accept) begin
            r_prio <= w_grant0;
        end
    end

    assign rsp_valid = (r_state == S_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus; a transaction-level model is compared every cycle and
// directed literal checks pin the expected results.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;

    // index 0 = RR_EN=1 instance, index 1 = RR_EN=0 instance
    logic [1:0]  d_req0_ready, d_req1_ready, d_rsp_valid, d_rsp_id, d_rsp_err;
    logic [31:0] d_rsp_data [2];

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(d_req0_ready[0]),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(d_req1_ready[0]),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(d_rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_data(d_rsp_data[0]), .rsp_id(d_rsp_id[0]), .rsp_err(d_rsp_err[0])
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(d_req0_ready[1]),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(d_req1_ready[1]),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(d_rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_data(d_rsp_data[1]), .rsp_id(d_rsp_id[1]), .rsp_err(d_rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the opcode table; returns {err, result}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sb;
        sh = a % 16;
        sb = b;
        case (op)
            4'd0: return {1'b0, a + b};
            4'd1: return {1'b0, a - b};
            4'd2: return {1'b0, b << sh};
            4'd3: return {1'b0, b >> sh};
            4'd4: return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
            4'd5: return {1'b0, a & b};
            4'd6: return {1'b0, a | b};
            4'd7: return {1'b0, a ^ b};
            4'd8: return {1'b0, ((a < b) ? 32'd1 : 32'd0)};
            4'd9: return {1'b0, 32'(sb >>> sh)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Transaction model: one result slot per instance and the requester
    // that was served last (the other one wins a tie in round-robin mode).
    logic        m_full [2];
    logic [31:0] m_data [2];
    logic        m_id   [2];
    logic        m_err  [2];
    logic        m_last [2];

    function automatic logic m_free(input int k);
        return !m_full[k] || rsp_ready;
    endfunction

    // Who would win a tie right now.
    function automatic logic m_tie_winner(input int k);
        return (k == 0) ? !m_last[k] : 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [32:0] r;
        logic        who;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_full[k] = 1'b0; m_data[k] = 32'd0; m_id[k] = 1'b0;
                m_err[k] = 1'b0;  m_last[k] = 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_free(k) && (req0_valid || req1_valid)) begin
                    if (req0_valid && req1_valid) who = m_tie_winner(k);
                    else who = req1_valid;
                    r = who ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
                    m_full[k] = 1'b1;
                    m_data[k] = r[31:0];
                    m_err[k]  = r[32];
                    m_id[k]   = who;
                    m_last[k] = who;
                end else if (rsp_ready) begin
                    m_full[k] = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc_valid[%0d]", k), {31'd0, d_rsp_valid[k]}, {31'd0, m_full[k]});
            check($sformatf("cyc_rdy0[%0d]", k), {31'd0, d_req0_ready[k]},
                  {31'd0, m_free(k) && (!req1_valid || !m_tie_winner(k))});
            check($sformatf("cyc_rdy1[%0d]", k), {31'd0, d_req1_ready[k]},
                  {31'd0, m_free(k) && (!req0_valid || m_tie_winner(k))});
            if (m_full[k]) begin
                check($sformatf("cyc_data[%0d]", k), d_rsp_data[k], m_data[k]);
                check($sformatf("cyc_id[%0d]", k), {31'd0, d_rsp_id[k]}, {31'd0, m_id[k]});
                check($sformatf("cyc_err[%0d]", k), {31'd0, d_rsp_err[k]}, {31'd0, m_err[k]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Single operation from req0 with a literal expected result.
    task automatic op_r0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_op = op; req0_a = a; req0_b = b;
        tick();
        check({name, "_data"}, d_rsp_data[0], exp);
        check({name, "_id"}, {31'd0, d_rsp_id[0]}, 32'd0);
        check({name, "_err"}, {31'd0, d_rsp_err[0]}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_valid", {31'd0, d_rsp_valid[0]}, 32'd0);
        check("rst_data", d_rsp_data[0], 32'd0);
        check("rst_rdy0", {31'd0, d_req0_ready[0]}, 32'd1);

        // single op, one-cycle latency
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5; req0_op = 4'b0000;
        tick();
        check("single_valid", {31'd0, d_rsp_valid[0]}, 32'd1);
        check("single_data", d_rsp_data[0], 32'd8);
        check("single_id", {31'd0, d_rsp_id[0]}, 32'd0);

        // asynchronous reset while FULL drops the result at once
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_valid_rr", {31'd0, d_rsp_valid[0]}, 32'd0);
        check("arst_valid_fp", {31'd0, d_rsp_valid[1]}, 32'd0);
        check("arst_data", d_rsp_data[0], 32'd0);
        rst_n = 1'b1;

        // contention: rr alternates starting with req0, fp always req0
        req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd10; req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 4'b0100; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_id_%0d", i), {31'd0, d_rsp_id[0]}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("rr_data_%0d", i), d_rsp_data[0], (i % 2 == 0) ? 32'd6 : 32'd1);
            check($sformatf("fp_id_%0d", i), {31'd0, d_rsp_id[1]}, 32'd0);
        end

        // backpressure: result held, both readies low, operand change ignored
        rsp_ready = 1'b0; req0_a = 32'd100;
        #1;
        check("bp_rdy0", {31'd0, d_req0_ready[0]}, 32'd0);
        check("bp_rdy1", {31'd0, d_req1_ready[0]}, 32'd0);
        tick();
        check("bp_hold_data", d_rsp_data[0], 32'd1);
        check("bp_hold_id", {31'd0, d_rsp_id[0]}, 32'd1);
        check("bp_hold_valid", {31'd0, d_rsp_valid[0]}, 32'd1);
        rsp_ready = 1'b1;
        #1;
        check("bp_rel_rdy0", {31'd0, d_req0_ready[0]}, 32'd1);
        check("bp_rel_rdy1", {31'd0, d_req1_ready[0]}, 32'd0);
        tick();
        check("bp_next_data", d_rsp_data[0], 32'd96);
        check("bp_next_id", {31'd0, d_rsp_id[0]}, 32'd0);

        // shift/compare corners and plain logic ops
        op_r0(4'b0010, 32'h13, 32'd1, 32'h8, "sll");
        op_r0(4'b1001, 32'd4, 32'h8000_0000, 32'hF800_0000, "sra");
        op_r0(4'b0011, 32'd4, 32'h8000_0000, 32'h0800_0000, "srl");
        op_r0(4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        op_r0(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, "addwrap");
        op_r0(4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF, "subwrap");
        op_r0(4'b0101, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, "and");
        op_r0(4'b0110, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "or");
        op_r0(4'b0111, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, "xor");

        // illegal op from req1, then a legal one clears the error
        req0_valid = 1'b0; req1_valid = 1'b1;
        req1_op = 4'b1100; req1_a = 32'd1; req1_b = 32'd2;
        tick();
        check("ill_data", d_rsp_data[0], 32'd0);
        check("ill_err", {31'd0, d_rsp_err[0]}, 32'd1);
        check("ill_id", {31'd0, d_rsp_id[0]}, 32'd1);
        check("fp_req1_alone_id", {31'd0, d_rsp_id[1]}, 32'd1);
        req1_op = 4'b0000;
        tick();
        check("legal_data", d_rsp_data[0], 32'd3);
        check("legal_err", {31'd0, d_rsp_err[0]}, 32'd0);

        // drain
        req1_valid = 1'b0;
        tick(); tick();
        check("drain_valid", {31'd0, d_rsp_valid[0]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
